// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared definitions for the ID/EX pipeline register and its hazard unit:
// datapath widths, opcode constants, control-word layout, ALUOp encodings
// and the operand-use decode helper.
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 9;

  // Control-word bit positions: {Branch,MemRead,MemtoReg,MemWrite,ALUSrc,
  // RegWrite,Shift,ALUOp[1:0]}
  localparam int CTRL_BRANCH   = 8;
  localparam int CTRL_MEMREAD  = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_SHIFT    = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_BEQ   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_BLT   = 2'b11
  } aluop_e;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
  } operand_use_t;

  // Which source registers an opcode actually reads; anything unlisted
  // (lui, jal, system, garbage) reads neither and so can never stall.
  function automatic operand_use_t decode_operand_use(input logic [6:0] opcode);
    operand_use_t use_v;
    case (opcode)
      OP_IMM:  use_v = '{uses_rs1: 1'b1, uses_rs2: 1'b0};
      OP_LD:   use_v = '{uses_rs1: 1'b1, uses_rs2: 1'b0};
      OP_R:    use_v = '{uses_rs1: 1'b1, uses_rs2: 1'b1};
      OP_SD:   use_v = '{uses_rs1: 1'b1, uses_rs2: 1'b1};
      OP_BR:   use_v = '{uses_rs1: 1'b1, uses_rs2: 1'b1};
      default: use_v = '{uses_rs1: 1'b0, uses_rs2: 1'b0};
    endcase
    return use_v;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Combinational load-use detector. Flags when the instruction in EX is a
// valid load writing a non-zero rd that the ID instruction reads.
// Ports:
//   i_ex_valid, i_ex_memread, i_ex_regwrite, i_ex_rd : EX-stage state
//   i_id_valid, i_id_opcode, i_id_rs1, i_id_rs2      : ID-stage instruction
//   o_haz                                            : load-use hazard
// ---------------------------------------------------------------------------
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REG_ADDR_W_P = REG_ADDR_W
) (
  input  logic                    i_ex_valid,
  input  logic                    i_ex_memread,
  input  logic                    i_ex_regwrite,
  input  logic [REG_ADDR_W_P-1:0] i_ex_rd,
  input  logic                    i_id_valid,
  input  logic [6:0]              i_id_opcode,
  input  logic [REG_ADDR_W_P-1:0] i_id_rs1,
  input  logic [REG_ADDR_W_P-1:0] i_id_rs2,
  output logic                    o_haz
);

  operand_use_t w_use;
  logic         w_ex_is_load;
  logic         w_match;

  // Operand-use decode and register-index match against the EX load
  always_comb begin
    w_use        = decode_operand_use(i_id_opcode);
    w_ex_is_load = i_ex_valid & i_ex_memread & i_ex_regwrite &
                   (i_ex_rd != {REG_ADDR_W_P{1'b0}});
    w_match      = (w_use.uses_rs1 & (i_id_rs1 == i_ex_rd)) |
                   (w_use.uses_rs2 & (i_id_rs2 == i_ex_rd));
    if (w_ex_is_load & i_id_valid) begin
      o_haz = w_match;
    end else begin
      o_haz = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use stall and flush bubble insertion.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   id_*                : decode-stage instruction fields and control word
//   flush               : kill the ID instruction (branch taken downstream)
//   stall               : combinational; hold PC and IF/ID this cycle
//   ex_*                : registered copies presented to EX
// ---------------------------------------------------------------------------
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN_P       = XLEN,
  parameter int REG_ADDR_W_P = REG_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [6:0]              id_opcode,
  input  logic [2:0]              id_funct3,
  input  logic                    id_funct7b5,
  input  logic [CTRL_W-1:0]       id_ctrl,
  input  logic [XLEN_P-1:0]       id_pc,
  input  logic [XLEN_P-1:0]       id_rs1_data,
  input  logic [XLEN_P-1:0]       id_rs2_data,
  input  logic [XLEN_P-1:0]       id_imm,
  input  logic [REG_ADDR_W_P-1:0] id_rs1,
  input  logic [REG_ADDR_W_P-1:0] id_rs2,
  input  logic [REG_ADDR_W_P-1:0] id_rd,
  input  logic                    flush,
  output logic                    stall,
  output logic                    ex_valid,
  output logic [CTRL_W-1:0]       ex_ctrl,
  output logic [XLEN_P-1:0]       ex_pc,
  output logic [XLEN_P-1:0]       ex_rs1_data,
  output logic [XLEN_P-1:0]       ex_rs2_data,
  output logic [XLEN_P-1:0]       ex_imm,
  output logic [REG_ADDR_W_P-1:0] ex_rs1,
  output logic [REG_ADDR_W_P-1:0] ex_rs2,
  output logic [REG_ADDR_W_P-1:0] ex_rd,
  output logic [2:0]              ex_funct3,
  output logic                    ex_funct7b5
);

  logic                    r_valid;
  logic [CTRL_W-1:0]       r_ctrl;
  logic [XLEN_P-1:0]       r_pc;
  logic [XLEN_P-1:0]       r_rs1_data;
  logic [XLEN_P-1:0]       r_rs2_data;
  logic [XLEN_P-1:0]       r_imm;
  logic [REG_ADDR_W_P-1:0] r_rs1;
  logic [REG_ADDR_W_P-1:0] r_rs2;
  logic [REG_ADDR_W_P-1:0] r_rd;
  logic [2:0]              r_funct3;
  logic                    r_funct7b5;
  logic                    w_haz;

  hazard_detect #(
    .REG_ADDR_W_P (REG_ADDR_W_P)
  ) u_hazard_detect (
    .i_ex_valid    (r_valid),
    .i_ex_memread  (r_ctrl[CTRL_MEMREAD]),
    .i_ex_regwrite (r_ctrl[CTRL_REGWRITE]),
    .i_ex_rd       (r_rd),
    .i_id_valid    (id_valid),
    .i_id_opcode   (id_opcode),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .o_haz         (w_haz)
  );

  // A flush discards the ID instruction upstream, so holding it is pointless
  always_comb begin
    if (flush) begin
      stall = 1'b0;
    end else begin
      stall = w_haz;
    end
  end

  // Pipeline register: reset, bubble on flush/hazard, else capture ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_ctrl     <= {CTRL_W{1'b0}};
      r_pc       <= {XLEN_P{1'b0}};
      r_rs1_data <= {XLEN_P{1'b0}};
      r_rs2_data <= {XLEN_P{1'b0}};
      r_imm      <= {XLEN_P{1'b0}};
      r_rs1      <= {REG_ADDR_W_P{1'b0}};
      r_rs2      <= {REG_ADDR_W_P{1'b0}};
      r_rd       <= {REG_ADDR_W_P{1'b0}};
      r_funct3   <= 3'b000;
      r_funct7b5 <= 1'b0;
    end else if (flush | w_haz) begin
      r_valid    <= 1'b0;
      r_ctrl     <= {CTRL_W{1'b0}};
      r_pc       <= {XLEN_P{1'b0}};
      r_rs1_data <= {XLEN_P{1'b0}};
      r_rs2_data <= {XLEN_P{1'b0}};
      r_imm      <= {XLEN_P{1'b0}};
      r_rs1      <= {REG_ADDR_W_P{1'b0}};
      r_rs2      <= {REG_ADDR_W_P{1'b0}};
      r_rd       <= {REG_ADDR_W_P{1'b0}};
      r_funct3   <= 3'b000;
      r_funct7b5 <= 1'b0;
    end else begin
      r_valid    <= id_valid;
      // Gate on id_valid so garbage/X control from an empty slot never lands
      r_ctrl     <= id_valid ? id_ctrl : {CTRL_W{1'b0}};
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
      r_funct3   <= id_funct3;
      r_funct7b5 <= id_funct7b5;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_ctrl     = r_ctrl;
  assign ex_pc       = r_pc;
  assign ex_rs1_data = r_rs1_data;
  assign ex_rs2_data = r_rs2_data;
  assign ex_imm      = r_imm;
  assign ex_rs1      = r_rs1;
  assign ex_rs2      = r_rs2;
  assign ex_rd       = r_rd;
  assign ex_funct3   = r_funct3;
  assign ex_funct7b5 = r_funct7b5;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode and execute.
- Captures the decode-stage control word (Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, Shift, ALUOp), operands, immediate and register indices, and presents them to EX one cycle later.
- Contains load-use hazard detection. On a hazard it raises a stall to the PC and IF/ID register and inserts a bubble into EX.
- Branch-resolution flush also inserts a bubble.

Parameters:
XLEN, 64, datapath width (ld/sd are doubleword)
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a real instruction
id_opcode  in  7  instruction[6:0], used for operand-use decode
id_funct3  in  3  instruction[14:12]
id_funct7b5  in  1  instruction[30]
id_ctrl  in  9  {Branch,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite,Shift,ALUOp[1:0]}
id_pc  in  XLEN  instruction PC
id_rs1_data, id_rs2_data  in  XLEN  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_rs1, id_rs2, id_rd  in  REG_ADDR_W  register indices
flush  in  1  branch taken in later stage; kill the ID instruction
stall  out  1  combinational; hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
ex_ctrl  out  9  registered control word, same bit order as id_ctrl
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies
ex_rs1, ex_rs2, ex_rd  out  REG_ADDR_W  registered copies
ex_funct3  out  3  registered copy
ex_funct7b5  out  1  registered copy

Behaviour:
- Reset (async, rst_n=0): every registered output is 0, so ex_valid=0 and ex_ctrl=0 (a bubble). stall is 0 while in reset.
- Operand use, decoded from id_opcode:
  - uses_rs1 = 1 for 0010011, 0110011, 0000011, 0100011, 1100011.
  - uses_rs2 = 1 for 0110011, 0100011, 1100011 only.
  - Unlisted opcodes use neither operand.
- Hazard: haz = ex_valid & ex_ctrl.MemRead & ex_ctrl.RegWrite & (ex_rd != 0) & id_valid & ((uses_rs1 & id_rs1 == ex_rd) | (uses_rs2 & id_rs2 == ex_rd)).
- stall = haz & ~flush. Combinational, no added latency.
- Sanitising: if id_valid=0, or id_ctrl contains X/illegal-opcode output, the captured control word must be forced to 0. Use id_valid gating; do not rely on X detection.
- Per rising edge, priority high to low:
  1. flush=1: load a bubble (ex_valid=0, ex_ctrl=0); data fields don't-care, implementation loads 0.
  2. haz=1: load a bubble. The ID instruction remains in IF/ID (stall=1) and is captured next cycle.
  3. Otherwise: ex_* <= id_*; ex_valid <= id_valid; ex_ctrl <= id_valid ? id_ctrl : 0.
- A bubble never causes a hazard, since ex_valid=0. A load-use stall therefore lasts exactly one cycle.
- rd=x0 never causes a stall.
- flush and haz in the same cycle: flush wins and stall=0, because the wrong-path instruction is discarded upstream.
- Reset asserted mid-stall: outputs clear immediately. After release, the first edge loads normally.
- Latency: 1 cycle from ID to EX. Throughput is 1 instruction per cycle except load-use (+1 cycle).

Decomposition:
- Shared package:
  - opcode constants (OP_IMM=0010011, OP_R=0110011, OP_LD=0000011, OP_SD=0100011, OP_BR=1100011)
  - CTRL_W=9 and control-word bit index constants
  - ALUOp encodings (00 add, 01 beq, 10 R-type, 11 blt)
- One sub-module, hazard_detect: purely combinational operand-use decode plus comparison, producing haz. It is instantiated once; the register bank stays in id_ex_stage.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle with pipeline loaded → all ex_* become 0 immediately and stall=0.
- Normal flow: add x6,x5,x7 (ctrl RegWrite=1, ALUOp=10), rs1 data=0x10, rs2 data=0x20 → next edge ex_ctrl matches, ex_rs1_data=0x10, ex_rd=6, ex_valid=1, stall=0.
- Load-use: ld x5,8(x2) followed by add x6,x5,x7 → stall=1 for exactly one cycle, EX gets a bubble (ex_ctrl=0), then add enters EX on the next edge.
- No false stall:
  - ld x5 then addi x6,x7,5 where imm bits[24:20]=5 → stall=0, since addi does not use rs2.
  - ld x0 then add x1,x0,x0 → stall=0.
- Flush priority: ld x5 in EX, add x6,x5,x7 in ID, flush=1 in the same cycle → stall=0 and a bubble is loaded.
- Invalid input: id_valid=0 with id_ctrl=9'h1FF → ex_valid=0 and ex_ctrl=0.
